// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types for the cache-to-RAM arbiter: RAM word, RAM
//                handshake state and the arbiter grant state.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of icache, dcache and RAM port signals plus the
//                arbiter's transaction counters. The arbiter uses the slave
//                modport; the environment (caches + RAM) uses master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int CNT_W = 16
);
    import mem_arbiter_pkg::*;

    // icache side
    logic             iREN;
    word_t            iaddr;
    logic             iwait;
    word_t            iload;
    // dcache side
    logic             dREN;
    logic             dWEN;
    word_t            daddr;
    word_t            dstore;
    logic             dwait;
    word_t            dload;
    // RAM side
    logic             ramREN;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    word_t            ramload;
    ramstate_t        ramstate;
    // statistics
    logic [CNT_W-1:0] icount;
    logic [CNT_W-1:0] dcount;
    logic [CNT_W-1:0] errcount;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output icount, dcount, errcount
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  icount, dcount, errcount
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         nRST,
    input  wire logic         inc_i,
    output logic [W-1:0]      count_o
);

    logic [W-1:0] count_q;

    // Count one per asserted inc, holding once every bit is set.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Registered-grant arbiter between icache and dcache onto a
//                single RAM port. Dcache wins ties and keeps the grant for
//                back-to-back block words; a starvation counter forces an
//                icache fetch after STARVE_MAX consecutive dcache words.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int STARVE_MAX = 8
) (
    input  wire logic    CLK,
    input  wire logic    nRST,
    mem_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;

    logic d_req;
    logic i_done;
    logic d_done;
    logic err_hit;

    assign d_req   = bus.dREN | bus.dWEN;
    assign i_done  = (state_q == GNT_I) && bus.iREN && (bus.ramstate == ACCESS);
    assign d_done  = (state_q == GNT_D) && d_req    && (bus.ramstate == ACCESS);
    assign err_hit = (state_q != IDLE)  && (bus.ramstate == ERROR);

    // Grant and starvation registers; reset abandons any in-flight access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next grant, starvation update and the RAM/cache output mux.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d = GNT_D;
                end else if (bus.iREN) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                starve_d    = '0;
                if (i_done) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (i_done) begin
                    state_d = d_req ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (d_done) begin
                    bus.dwait = 1'b0;
                    if (bus.dREN) begin
                        bus.dload = bus.ramload;
                    end
                    if (starve_q != SW'(STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
                // The word completing now is number starve_q+1, so yield once
                // that count reaches STARVE_MAX with an icache fetch waiting.
                if (!d_req) begin
                    state_d = IDLE;
                end else if (d_done && bus.iREN && (starve_q >= SW'(STARVE_MAX - 1))) begin
                    state_d = GNT_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_icount (
        .clk     (CLK),
        .nRST    (nRST),
        .inc_i   (i_done),
        .count_o (bus.icount)
    );

    sat_counter #(.W(CNT_W)) u_dcount (
        .clk     (CLK),
        .nRST    (nRST),
        .inc_i   (d_done),
        .count_o (bus.dcount)
    );

    sat_counter #(.W(CNT_W)) u_errcount (
        .clk     (CLK),
        .nRST    (nRST),
        .inc_i   (err_hit),
        .count_o (bus.errcount)
    );

endmodule
`default_nettype wire
